collide_scan_ctrl: RTL

//  Time-multiplexed collision scheduler. On start, snapshots the packed object table and walks
//  the enemy slots one per clk3 cycle through a single shared AABB comparator against slot 0
//  (the player). Reports a sticky collide flag, the first hit slot index and a one-cycle done.

---
 rtl/collide_scan_ctrl_pkg.sv | 35 +++
 rtl/collide_scan_ctrl_aabb_overlap.sv | 30 +++
 rtl/collide_scan_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/collide_scan_ctrl_pkg.sv
// Shared definitions for the collision scan controller: slot record layout,
// enemy type code, FSM state encoding and a field extract helper.
package collide_scan_ctrl_pkg;

  // Default table geometry
  localparam int DATACOUNT_DEF = 4;

  // Slot record layout: {type[3:0], h[7:0], y[7:0], w[7:0], x[7:0]}
  localparam int FIELD_W    = 8;
  localparam int X_START    = 0;
  localparam int W_START    = 8;
  localparam int Y_START    = 16;
  localparam int H_START    = 24;
  localparam int GEOM_LEN   = 32;
  localparam int TYPE_START = 32;
  localparam int TYPE_LEN   = 4;
  localparam int SLOT_LEN   = 36;

  localparam logic [TYPE_LEN-1:0] ENEMY_TYPE = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Pull one geometry field out of the geometry part of a slot record
  function automatic logic [FIELD_W-1:0] aabb_field(input logic [GEOM_LEN-1:0] geom,
                                                    input int unsigned start_bit);
    logic [GEOM_LEN-1:0] shifted;
    shifted = geom >> start_bit;
    return shifted[FIELD_W-1:0];
  endfunction

endpackage

// File: rtl/collide_scan_ctrl_aabb_overlap.sv
// Combinational inclusive AABB overlap test between two slot geometries.
// End coordinates are formed one bit wider than the fields so x+w never wraps.
module aabb_overlap
  import collide_scan_ctrl_pkg::*;
(
  input  logic [GEOM_LEN-1:0] a_i,
  input  logic [GEOM_LEN-1:0] b_i,
  output logic                overlap_o
);

  logic [FIELD_W:0] a_x_s, a_xe_s, b_x_s, b_xe_s;
  logic [FIELD_W:0] a_y_s, a_ye_s, b_y_s, b_ye_s;
  logic             ov_x_s, ov_y_s;

  // Widened start/end coordinates and the per-axis separation tests
  always_comb begin
    a_x_s  = {1'b0, aabb_field(a_i, X_START)};
    b_x_s  = {1'b0, aabb_field(b_i, X_START)};
    a_y_s  = {1'b0, aabb_field(a_i, Y_START)};
    b_y_s  = {1'b0, aabb_field(b_i, Y_START)};
    a_xe_s = a_x_s + {1'b0, aabb_field(a_i, W_START)};
    b_xe_s = b_x_s + {1'b0, aabb_field(b_i, W_START)};
    a_ye_s = a_y_s + {1'b0, aabb_field(a_i, H_START)};
    b_ye_s = b_y_s + {1'b0, aabb_field(b_i, H_START)};
    ov_x_s = !((a_xe_s < b_x_s) || (b_xe_s < a_x_s));
    ov_y_s = !((a_ye_s < b_y_s) || (b_ye_s < a_y_s));
    overlap_o = ov_x_s && ov_y_s;
  end

endmodule

// File: rtl/collide_scan_ctrl.sv
// Time-multiplexed collision scheduler: snapshots the object table on start
// and walks enemy slots one per clock through a single shared AABB comparator
// against the player in slot 0. Early-exits on the lowest colliding slot.
module collide_scan_ctrl
  import collide_scan_ctrl_pkg::*;
#(
  parameter int DATACOUNT = DATACOUNT_DEF,
  parameter int DATALEN   = SLOT_LEN,
  parameter int IDXW      = 4
) (
  input  logic                         clk3,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DATALEN*DATACOUNT-1:0] gamedata,
  output logic                         busy,
  output logic                         done,
  output logic                         collide,
  output logic [IDXW-1:0]              hit_idx
);

  state_e              state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [IDXW-1:0]     hit_idx_q, hit_idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                collide_q, collide_d;
  logic                snap_load_s;
  logic                overlap_s, hit_s, last_s;
  logic [DATALEN-1:0]  snap_q [DATACOUNT];
  logic [DATALEN-1:0]  cur_slot_s;

  // Snapshot register: the whole table is captured once per accepted start
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DATACOUNT; i++) snap_q[i] <= '0;
    end else if (snap_load_s) begin
      for (int i = 0; i < DATACOUNT; i++) snap_q[i] <= gamedata[i*DATALEN +: DATALEN];
    end
  end

  // Select the slot currently under evaluation
  always_comb begin
    cur_slot_s = snap_q[0];
    for (int i = 1; i < DATACOUNT; i++) begin
      cur_slot_s = (idx_q == IDXW'(i)) ? snap_q[i] : cur_slot_s;
    end
  end

  aabb_overlap u_aabb (
    .a_i      (snap_q[0][GEOM_LEN-1:0]),
    .b_i      (cur_slot_s[GEOM_LEN-1:0]),
    .overlap_o(overlap_s)
  );

  // Only enemy-typed slots can collide; detect the final slot of the walk
  always_comb begin
    hit_s  = (cur_slot_s[TYPE_START +: TYPE_LEN] == ENEMY_TYPE) && overlap_s;
    last_s = (idx_q == IDXW'(DATACOUNT-1));
  end

  // Next-state and output-register decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hit_idx_d   = hit_idx_q;
    collide_d   = collide_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    snap_load_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_load_s = 1'b1;
          idx_d       = IDXW'(1);
          collide_d   = 1'b0;
          hit_idx_d   = '0;
          busy_d      = 1'b1;
          if (DATACOUNT == 1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SCAN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (hit_s) begin
          collide_d = 1'b1;
          hit_idx_d = idx_q;
          state_d   = ST_DONE;
          done_d    = 1'b1;
        end else if (last_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, index and output registers; reset aborts any scan in flight
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      hit_idx_q <= '0;
      collide_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hit_idx_q <= hit_idx_d;
      collide_q <= collide_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign collide = collide_q;
  assign hit_idx = hit_idx_q;

endmodule
